// File: rtl/wb_burst_pkg.sv
// Shared constants and state encoding for the Wishbone burst traffic master.
package wb_burst_pkg;

  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_EOB     = 3'b111;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0] LFSR_TAP    = 32'h80200003;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StDone = 2'd2
  } state_e;

  // An all-zero state would lock the LFSR, so seed 0 is promoted to 1.
  function automatic logic [31:0] lfsr_seed(input logic [31:0] seed);
    return (seed == 32'h0) ? 32'h1 : seed;
  endfunction

endpackage

// File: rtl/lfsr32_step.sv
// One combinational step of the 32-bit Galois LFSR used for write data and read prediction.
module lfsr32_step
  import wb_burst_pkg::*;
(
  input  logic [31:0] i_state,
  output logic [31:0] o_next
);

  assign o_next = i_state[0] ? ((i_state >> 1) ^ LFSR_TAP) : (i_state >> 1);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst traffic master: LFSR write data, LFSR-predicted read check,
// per-beat ack watchdog, error count and first failing address.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int unsigned dw     = 32,
  parameter int unsigned APP_AW = 26,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned TO_CYC = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_seed,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic              done_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [15:0]       err_cnt_o,
  output logic [APP_AW-1:0] first_err_addr_o
);

  localparam int unsigned       WdogW   = $clog2(TO_CYC + 1);
  localparam logic [WdogW-1:0]  WdogMax = WdogW'(TO_CYC - 1);
  localparam logic [APP_AW-1:0] AddrInc = APP_AW'(dw / 8);

  state_e              r_state, w_state_d;
  logic [APP_AW-1:0]   r_addr, w_addr_d;
  logic [LEN_W-1:0]    r_cnt, w_cnt_d;
  logic [31:0]         r_lfsr, w_lfsr_d;
  logic                r_we, w_we_d;
  logic                r_single, w_single_d;
  logic [WdogW-1:0]    r_wdog, w_wdog_d;
  logic [15:0]         r_err_cnt, w_err_cnt_d;
  logic [APP_AW-1:0]   r_first_err, w_first_err_d;
  logic                r_timeout, w_timeout_d;

  logic                r_cmd_ready, w_cmd_ready_d;
  logic                r_cyc, w_cyc_d;
  logic                r_we_o, w_we_o_d;
  logic [APP_AW-1:0]   r_addr_o, w_addr_o_d;
  logic [dw-1:0]       r_dat_o, w_dat_o_d;
  logic [dw/8-1:0]     r_sel, w_sel_d;
  logic [2:0]          r_cti, w_cti_d;
  logic                r_done, w_done_d;
  logic                r_busy, w_busy_d;

  logic [31:0]         w_lfsr_nxt;
  logic                w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^cmd_addr[1:0];

  lfsr32_step u_lfsr_step (
    .i_state (r_lfsr),
    .o_next  (w_lfsr_nxt)
  );

  always_comb begin
    w_state_d     = r_state;
    w_addr_d      = r_addr;
    w_cnt_d       = r_cnt;
    w_lfsr_d      = r_lfsr;
    w_we_d        = r_we;
    w_single_d    = r_single;
    w_wdog_d      = r_wdog;
    w_err_cnt_d   = r_err_cnt;
    w_first_err_d = r_first_err;
    w_timeout_d   = r_timeout;

    unique case (r_state)
      StIdle: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_d     = StBus;
          w_addr_d      = {cmd_addr[APP_AW-1:2], 2'b00};
          w_cnt_d       = cmd_len;
          w_lfsr_d      = lfsr_seed(cmd_seed);
          w_we_d        = cmd_we;
          w_single_d    = (cmd_len == '0);
          w_wdog_d      = '0;
          w_err_cnt_d   = '0;
          w_first_err_d = '0;
          w_timeout_d   = 1'b0;
        end
      end
      StBus: begin
        if (wb_ack_i) begin
          if (!r_we && (wb_dat_i != dw'(r_lfsr))) begin
            if (r_err_cnt == 16'h0) w_first_err_d = r_addr;
            if (r_err_cnt != 16'hFFFF) w_err_cnt_d = r_err_cnt + 16'd1;
          end
          w_addr_d = r_addr + AddrInc;
          w_lfsr_d = w_lfsr_nxt;
          w_cnt_d  = r_cnt - LEN_W'(1);
          w_wdog_d = '0;
          if (r_cnt == '0) w_state_d = StDone;
        end else if (r_wdog == WdogMax) begin
          // Slave went silent: abandon the rest of the burst.
          w_timeout_d = 1'b1;
          w_state_d   = StDone;
        end else begin
          w_wdog_d = r_wdog + WdogW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    w_cyc_d       = (w_state_d == StBus);
    w_we_o_d      = w_cyc_d && w_we_d;
    w_addr_o_d    = w_cyc_d ? w_addr_d : '0;
    w_dat_o_d     = w_we_o_d ? dw'(w_lfsr_d) : '0;
    w_sel_d       = w_cyc_d ? '1 : '0;
    if (!w_cyc_d) begin
      w_cti_d = CTI_CLASSIC;
    end else if (w_single_d) begin
      w_cti_d = CTI_CLASSIC;
    end else if (w_cnt_d == '0) begin
      w_cti_d = CTI_EOB;
    end else begin
      w_cti_d = CTI_INCR;
    end
    w_done_d      = (w_state_d == StDone);
    w_busy_d      = (w_state_d != StIdle);
    w_cmd_ready_d = (w_state_d == StIdle) && sdr_init_done;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_lfsr      <= 32'h1;
      r_we        <= 1'b0;
      r_single    <= 1'b0;
      r_wdog      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_timeout   <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_we_o      <= 1'b0;
      r_addr_o    <= '0;
      r_dat_o     <= '0;
      r_sel       <= '0;
      r_cti       <= CTI_CLASSIC;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_cnt       <= w_cnt_d;
      r_lfsr      <= w_lfsr_d;
      r_we        <= w_we_d;
      r_single    <= w_single_d;
      r_wdog      <= w_wdog_d;
      r_err_cnt   <= w_err_cnt_d;
      r_first_err <= w_first_err_d;
      r_timeout   <= w_timeout_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_cyc       <= w_cyc_d;
      r_we_o      <= w_we_o_d;
      r_addr_o    <= w_addr_o_d;
      r_dat_o     <= w_dat_o_d;
      r_sel       <= w_sel_d;
      r_cti       <= w_cti_d;
      r_done      <= w_done_d;
      r_busy      <= w_busy_d;
    end
  end

  assign cmd_ready        = r_cmd_ready;
  assign wb_cyc_o         = r_cyc;
  assign wb_stb_o         = r_cyc;
  assign wb_we_o          = r_we_o;
  assign wb_addr_o        = r_addr_o;
  assign wb_dat_o         = r_dat_o;
  assign wb_sel_o         = r_sel;
  assign wb_cti_o         = r_cti;
  assign done_o           = r_done;
  assign busy_o           = r_busy;
  assign timeout_o        = r_timeout;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first_err;

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench for wb_burst_master: behavioural model checked every cycle plus pinned literals.
module tb_wb_burst_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned LW = 8;
  localparam int unsigned TO = 1024;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          sdr_init_done = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [31:0]   cmd_seed = '0;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;
  logic          done_o, busy_o, timeout_o;
  logic [15:0]   err_cnt_o;
  logic [AW-1:0] first_err_addr_o;

  always #5 clk = ~clk;

  wb_burst_master #(.dw(DW), .APP_AW(AW), .LEN_W(LW), .TO_CYC(TO)) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (wb_rst_i),
    .sdr_init_done    (sdr_init_done),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_we           (cmd_we),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .cmd_seed         (cmd_seed),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_addr_o        (wb_addr_o),
    .wb_dat_o         (wb_dat_o),
    .wb_sel_o         (wb_sel_o),
    .wb_cti_o         (wb_cti_o),
    .wb_ack_i         (wb_ack_i),
    .wb_dat_i         (wb_dat_i),
    .done_o           (done_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 60) $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  // Slave: memory written by acked write beats, random ack, optional read corruption.
  logic [31:0]   mem [logic [AW-1:0]];
  int            g_ack_pct = 100;
  int            g_flip_pct = 0;
  bit            g_corrupt_en = 0;
  logic [AW-1:0] g_corrupt_addr = '0;

  always @(posedge clk) begin
    #1;
    wb_ack_i = (int'($urandom_range(99)) < g_ack_pct);
    if (mem.exists(wb_addr_o)) wb_dat_i = mem[wb_addr_o];
    else wb_dat_i = $urandom;
    if ((g_corrupt_en && wb_addr_o == g_corrupt_addr) || (int'($urandom_range(99)) < g_flip_pct))
      wb_dat_i = wb_dat_i ^ (32'h1 << $urandom_range(31));
  end

  // Behavioural model: command = list of beats; progress measured in acked beats.
  bit            m_valid = 0;
  int            m_phase = 0;  // 0 idle, 1 burst in flight, 2 completion cycle
  logic          m_ready = 0;
  int            m_k = 0;
  int            m_beats = 1;
  logic [AW-1:0] m_base = '0;
  logic          m_we = 0;
  logic [31:0]   m_seq [256];
  int            m_wdog = 0;
  logic [15:0]   m_err = '0;
  logic [AW-1:0] m_first = '0;
  logic          m_timeout = 0;

  logic [AW-1:0] log_addr [$];
  logic [31:0]   log_dat [$];
  logic [2:0]    log_cti [$];

  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic [31:0]   s;
    logic          bus;
    a   = m_base + AW'(m_k * 4);
    bus = (m_phase == 1);
    if (m_valid) begin
      chk("cyc", wb_cyc_o, bus);
      chk("stb", wb_stb_o, bus);
      chk("we", wb_we_o, bus && m_we);
      chk("addr", wb_addr_o, bus ? a : '0);
      chk("wdata", wb_dat_o, (bus && m_we) ? m_seq[m_k] : 32'h0);
      chk("sel", wb_sel_o, bus ? 4'hF : 4'h0);
      chk("cti", wb_cti_o, !bus ? 3'b000 : (m_beats == 1) ? 3'b000 :
                           (m_k == m_beats - 1) ? 3'b111 : 3'b010);
      chk("done", done_o, m_phase == 2);
      chk("busy", busy_o, m_phase != 0);
      chk("cmd_ready", cmd_ready, m_ready);
      chk("timeout", timeout_o, m_timeout);
      chk("err_cnt", err_cnt_o, m_err);
      chk("first_err", first_err_addr_o, m_first);
    end
    if (wb_rst_i) begin
      m_valid = 1; m_phase = 0; m_ready = 0; m_k = 0; m_beats = 1; m_base = '0;
      m_we = 0; m_wdog = 0; m_err = '0; m_first = '0; m_timeout = 0;
    end else if (m_valid) begin
      case (m_phase)
        0: if (cmd_valid && m_ready) begin
          m_beats = int'(cmd_len) + 1;
          m_base  = {cmd_addr[AW-1:2], 2'b00};
          m_we    = cmd_we;
          m_k     = 0;
          m_wdog  = 0;
          m_err   = '0;
          m_first = '0;
          m_timeout = 0;
          s = (cmd_seed == 0) ? 32'h1 : cmd_seed;
          for (int i = 0; i < m_beats; i++) begin
            m_seq[i] = s;
            s = lfsr_next(s);
          end
          m_phase = 1;
        end
        1: if (wb_ack_i) begin
          log_addr.push_back(wb_addr_o);
          log_dat.push_back(wb_dat_o);
          log_cti.push_back(wb_cti_o);
          if (m_we) begin
            mem[a] = wb_dat_o;
          end else if (wb_dat_i !== m_seq[m_k]) begin
            if (m_err == 16'h0) m_first = a;
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          end
          m_wdog = 0;
          if (m_k == m_beats - 1) m_phase = 2;
          else m_k++;
        end else if (m_wdog == int'(TO) - 1) begin
          m_timeout = 1;
          m_phase = 2;
        end else begin
          m_wdog++;
        end
        default: m_phase = 0;
      endcase
      m_ready = (m_phase == 0) && sdr_init_done;
    end
  end

  task automatic start_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [31:0] seed, output bit ok);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = (cmd_ready === 1'b1);
    if (!ok) begin
      chk("ready_wait", cmd_ready, 1);
      return;
    end
    cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_seed = seed; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until done_o is visible; junk commands are offered meanwhile.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < limit) begin
      cmd_valid = 1'($urandom); cmd_we = 1'($urandom);
      cmd_addr = AW'($urandom); cmd_len = LW'($urandom); cmd_seed = $urandom;
      @(posedge clk); #1; cyc++;
    end
    cmd_valid = 1'b0;
    if (done_o !== 1'b1) chk("done_wait", done_o, 1);
  endtask

  task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input logic [31:0] seed, output int cyc);
    bit ok;
    log_addr.delete(); log_dat.delete(); log_cti.delete();
    cyc = 0;
    start_cmd(we, addr, len, seed, ok);
    if (!ok) return;
    wait_done(20000, cyc);
  endtask

  initial begin
    int cyc;
    bit ok;
    logic          lw_we;
    logic [AW-1:0] lw_addr, r_addr;
    logic [LW-1:0] lw_len, r_len;
    logic [31:0]   lw_seed, r_seed;
    bit            have_w;

    // Reset, then a pending command while the controller is not initialised.
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 26'h40;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("no_init_ready", cmd_ready, 0);
    chk("no_init_cyc", wb_cyc_o, 0);
    cmd_valid = 1'b0;
    sdr_init_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Four-beat write against a zero-wait slave.
    g_ack_pct = 100;
    run_cmd(1'b1, 26'h100, 8'd3, 32'h1, cyc);
    chk("wr_latency", cyc, 4);
    @(posedge clk); #1;
    chk("done_pulse", done_o, 0);
    chk("wr_beats", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      chk("wr_addr0", log_addr[0], 26'h100);
      chk("wr_addr1", log_addr[1], 26'h104);
      chk("wr_addr2", log_addr[2], 26'h108);
      chk("wr_addr3", log_addr[3], 26'h10C);
      chk("wr_cti0", log_cti[0], 3'b010);
      chk("wr_cti2", log_cti[2], 3'b010);
      chk("wr_cti3", log_cti[3], 3'b111);
      chk("wr_dat0", log_dat[0], 32'h00000001);
      chk("wr_dat1", log_dat[1], 32'h80200003);
      chk("wr_dat2", log_dat[2], 32'hC0300002);
      chk("wr_dat3", log_dat[3], 32'h60180001);
    end

    // Clean read-back, then read-back with beat 2 corrupted.
    run_cmd(1'b0, 26'h100, 8'd3, 32'h1, cyc);
    chk("rd_clean_err", err_cnt_o, 0);
    g_corrupt_en = 1; g_corrupt_addr = 26'h108;
    run_cmd(1'b0, 26'h100, 8'd3, 32'h1, cyc);
    chk("rd_bad_err", err_cnt_o, 1);
    chk("rd_bad_addr", first_err_addr_o, 26'h108);
    g_corrupt_en = 0;

    // Single beat with seed 0.
    run_cmd(1'b1, 26'h200, 8'd0, 32'h0, cyc);
    chk("single_beats", log_cti.size(), 1);
    if (log_cti.size() == 1) begin
      chk("single_cti", log_cti[0], 3'b000);
      chk("single_dat", log_dat[0], 32'h1);
    end

    // Address wrap at the top of the space.
    run_cmd(1'b1, 26'h3FFFFFC, 8'd1, 32'h5, cyc);
    chk("wrap_beats", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("wrap_addr0", log_addr[0], 26'h3FFFFFC);
      chk("wrap_addr1", log_addr[1], 26'h0);
    end

    // Silent slave trips the watchdog.
    g_ack_pct = 0;
    run_cmd(1'b1, 26'h40, 8'd2, 32'h77, cyc);
    chk("to_latency", cyc, TO);
    chk("to_flag", timeout_o, 1);
    chk("to_cyc", wb_cyc_o, 0);

    // Reset in the middle of a burst.
    start_cmd(1'b0, 26'h80, 8'd5, 32'h9, ok);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_cyc", wb_cyc_o, 1);
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_addr", wb_addr_o, 0);
    wb_rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic, reads often replaying the previous write.
    have_w = 0;
    lw_we = 0; lw_addr = '0; lw_len = '0; lw_seed = '0;
    for (int i = 0; i < 40; i++) begin
      g_ack_pct  = int'($urandom_range(100, 35));
      g_flip_pct = int'($urandom_range(3));
      lw_we = 1'($urandom);
      if (!lw_we && have_w && $urandom_range(1) == 1) begin
        r_addr = lw_addr; r_len = lw_len; r_seed = lw_seed;
      end else begin
        r_addr = (i % 6 == 0) ? (26'h3FFFFF0 | AW'($urandom_range(15))) : AW'($urandom_range(4095));
        r_len  = LW'($urandom_range(15));
        r_seed = (i % 7 == 0) ? 32'h0 : $urandom;
      end
      if (lw_we) begin
        have_w = 1; lw_addr = r_addr; lw_len = r_len; lw_seed = r_seed;
      end
      run_cmd(lw_we, r_addr, r_len, r_seed, cyc);
    end
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
